// File: rtl/spi_inst_loader.sv
// spi_inst_loader: deserialises MSB-first SPI boot words and writes them to instruction RAM.
// Define SPI_LOADER_CHKSUM_EN to add checksum_o, the running sum of retired write data.
module spi_inst_loader #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    GAP_BITS   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  spi_ss,
    input  logic                  spi_mosi,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic                  mem_gnt_i,
    output logic [15:0]           word_cnt_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o
`ifdef SPI_LOADER_CHKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum_o
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [4:0]            r_bit_cnt;
    logic [2:0]            r_gap_cnt;
    logic                  r_wvalid;
    logic                  r_pend;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [15:0]           r_word_cnt;
    logic                  r_ovf;

    logic w_go, w_last, w_retire, w_accept;

    assign w_go     = en_i && !spi_ss;
    assign w_last   = (r_state == SHIFT) && (r_bit_cnt == 5'(DATA_WIDTH-1));
    assign w_retire = r_pend && mem_gnt_i;
    // A finished word waits one cycle in r_shreg (r_wvalid) before it may enter the buffer.
    assign w_accept = r_wvalid && (!r_pend || w_retire) && (r_word_cnt != 16'hFFFF);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_wvalid  <= 1'b0;
        end else begin
            r_wvalid <= 1'b0;
            if (!w_go) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_shreg   <= {r_shreg[DATA_WIDTH-2:0], spi_mosi};
                        r_bit_cnt <= 5'd1;
                        r_state   <= SHIFT;
                    end
                    SHIFT: begin
                        r_shreg <= {r_shreg[DATA_WIDTH-2:0], spi_mosi};
                        if (w_last) begin
                            r_wvalid  <= 1'b1;
                            r_bit_cnt <= '0;
                            r_gap_cnt <= '0;
                            if (GAP_BITS > 0) r_state <= GAP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                    GAP: begin
                        if (r_gap_cnt == 3'(GAP_BITS-1)) r_state <= SHIFT;
                        else r_gap_cnt <= r_gap_cnt + 3'd1;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_word_cnt <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pend     <= 1'b1;
                r_addr     <= BASE_ADDR + (ADDR_WIDTH'(r_word_cnt) << 2);
                r_wdata    <= r_shreg;
                r_word_cnt <= r_word_cnt + 16'd1;
            end else if (w_retire) begin
                r_pend <= 1'b0;
            end
            if (r_wvalid && !w_accept) r_ovf <= 1'b1;
        end
    end

`ifdef SPI_LOADER_CHKSUM_EN
    logic [DATA_WIDTH-1:0] r_chk;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       r_chk <= '0;
        else if (w_retire) r_chk <= r_chk + r_wdata;
    end
    assign checksum_o = r_chk;
`endif

    assign mem_req_o   = r_pend;
    assign mem_we_o    = r_pend;
    assign mem_be_o    = {4{r_pend}};
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign word_cnt_o  = r_word_cnt;
    assign overflow_o  = r_ovf;
    assign busy_o      = (r_state != IDLE) || r_pend || r_wvalid;
    assign done_o      = (r_word_cnt != 16'd0) && spi_ss && !r_pend && !r_wvalid;

endmodule

// File: tb/tb_spi_inst_loader.sv
// Directed bench for spi_inst_loader: a write-queue model checked on every cycle plus literal pins.
// Covers the checksum output too when SPI_LOADER_CHKSUM_EN is defined.
module tb_spi_inst_loader;

    localparam logic [31:0] BASE = 32'h0;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, ss = 1'b1, mosi = 1'b0, gnt = 1'b0;
    logic        req, we, busy, done, ovf;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [15:0] cnt;
`ifdef SPI_LOADER_CHKSUM_EN
    logic [31:0] chksum;
`endif

    spi_inst_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(BASE), .GAP_BITS(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .spi_ss(ss), .spi_mosi(mosi),
        .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr), .mem_wdata_o(wdata),
        .mem_be_o(be), .mem_gnt_i(gnt), .word_cnt_o(cnt), .busy_o(busy),
        .done_o(done), .overflow_o(ovf)
`ifdef SPI_LOADER_CHKSUM_EN
        , .checksum_o(chksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
    wr_t         exp_q[$];
    logic [31:0] log_a[$], log_d[$];
    int          m_cnt;
    bit          m_ovf;
    int          errors = 0, checks = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_a, prev_d;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Model: a word is written iff no earlier write is still outstanding when it completes.
    task automatic model_word(input logic [31:0] w);
        if (exp_q.size() != 0 || m_cnt == 16'hFFFF) m_ovf = 1'b1;
        else begin
            exp_q.push_back('{BASE + 32'(4 * m_cnt), w});
            m_cnt++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) prev_stall = 1'b0;
        else begin
            chk("we", we, req ? 1'b1 : 1'b0);
            chk("be", be, req ? 4'hF : 4'h0);
            if (prev_stall) begin
                chk("stall_req", req, 1'b1);
                chk("stall_addr", addr, prev_a);
                chk("stall_data", wdata, prev_d);
            end
            if (req && gnt) begin
                chk("write_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    chk("wr_addr", addr, exp_q[0].a);
                    chk("wr_data", wdata, exp_q[0].d);
                    void'(exp_q.pop_front());
                end
                log_a.push_back(addr);
                log_d.push_back(wdata);
            end
            prev_stall = req && !gnt;
            prev_a = addr;
            prev_d = wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap_after);
        for (int i = 31; i >= 0; i--) begin
            ss = 1'b0;
            mosi = w[i];
            if (i == 0) model_word(w);
            tick();
        end
        if (gap_after) begin
            mosi = 1'b0;
            tick();
        end
    endtask

    task automatic end_frame();
        ss = 1'b1;
        tick();
    endtask

    task automatic do_reset(input logic g);
        rst_n = 1'b0;
        ss = 1'b1;
        en = 1'b1;
        gnt = g;
        exp_q.delete();
        log_a.delete();
        log_d.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input int max);
        for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_req"}, req, 0);
        chk({nm, "_addr"}, addr, 0);
        chk({nm, "_wdata"}, wdata, 0);
        chk({nm, "_be"}, be, 0);
        chk({nm, "_we"}, we, 0);
        chk({nm, "_cnt"}, cnt, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_ovf"}, ovf, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        #1;
        check_idle_outputs("reset");

        // 1: single word, latency pinned
        do_reset(1'b1);
        send_word(32'hDEADBEEF, 1'b0);
        chk("lat_edgeN", req, 0);
        end_frame();
        chk("lat_edgeN1", req, 1);
        chk("t1_be", be, 4'hF);
        tick();
        tick();
        chk("t1_addr", log_a[0], 32'h0);
        chk("t1_data", log_d[0], 32'hDEADBEEF);
        chk("t1_cnt", cnt, 16'd1);
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_ovf", ovf, 0);
        ss = 1'b0;
        #1;
        chk("t1_done_ss_low", done, 0);
        ss = 1'b1;
        tick();

        // 2: four back-to-back words
        do_reset(1'b1);
        send_word(32'h00000013, 1'b1);
        send_word(32'h00100093, 1'b1);
        send_word(32'hFFF00113, 1'b1);
        send_word(32'h0000006F, 1'b0);
        end_frame();
        wait_drain(10);
        tick();
        chk("t2_a1", log_a[1], 32'h4);
        chk("t2_a2", log_a[2], 32'h8);
        chk("t2_a3", log_a[3], 32'hC);
        chk("t2_d3", log_d[3], 32'h0000006F);
        chk("t2_cnt", cnt, m_cnt);
        chk("t2_ovf", ovf, 0);
        chk("t2_done", done, 1);

        // 3: grant withheld for 70 cycles
        do_reset(1'b0);
        fork
            begin
                send_word(32'h11111111, 1'b1);
                send_word(32'h22222222, 1'b1);
                send_word(32'h33333333, 1'b0);
                end_frame();
            end
            begin
                repeat (60) tick();
                chk("t3_hold_req", req, 1);
                chk("t3_hold_addr", addr, 32'h0);
                chk("t3_hold_data", wdata, 32'h11111111);
                repeat (10) tick();
                gnt = 1'b1;
            end
        join
        wait_drain(10);
        tick();
        chk("t3_ovf", ovf, 1);
        chk("t3_ovf_model", ovf, m_ovf);
        chk("t3_cnt", cnt, 16'd2);
        chk("t3_a1", log_a[1], 32'h4);
        chk("t3_d1", log_d[1], 32'h33333333);

        // 4: frame aborted after 17 bits
        do_reset(1'b1);
        begin
            logic [31:0] pw;
            pw = 32'hA5A5A5A5;
            for (int i = 31; i >= 15; i--) begin
                ss = 1'b0;
                mosi = pw[i];
                tick();
            end
        end
        end_frame();
        tick();
        chk("t4_busy", busy, 0);
        chk("t4_req", req, 0);
        chk("t4_cnt", cnt, 0);
        send_word(32'h12345678, 1'b0);
        end_frame();
        wait_drain(10);
        tick();
        chk("t4_addr", log_a[0], 32'h0);
        chk("t4_data", log_d[0], 32'h12345678);
        chk("t4_cnt2", cnt, 16'd1);

        // 5: reset while a write is pending
        do_reset(1'b0);
        send_word(32'hCAFEF00D, 1'b0);
        end_frame();
        tick();
        chk("t5_req_before", req, 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t5_async");
        exp_q.delete();
        log_a.delete();
        log_d.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        tick();
        rst_n = 1'b1;
        gnt = 1'b1;
        tick();
        send_word(32'h0BADCAFE, 1'b0);
        end_frame();
        wait_drain(10);
        tick();
        chk("t5_addr", log_a[0], BASE);
        chk("t5_data", log_d[0], 32'h0BADCAFE);
        chk("t5_cnt", cnt, 16'd1);

`ifdef SPI_LOADER_CHKSUM_EN
        // 6: checksum wraps mod 2^32
        do_reset(1'b1);
        chk("t6_chk_reset", chksum, 0);
        send_word(32'h00000001, 1'b1);
        send_word(32'h00000002, 1'b1);
        send_word(32'hFFFFFFFF, 1'b0);
        end_frame();
        wait_drain(10);
        tick();
        chk("t6_chksum", chksum, 32'h00000002);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
